// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] OP_UMULL = 2'b00;
   localparam logic [1:0] OP_SMULL = 2'b01;
   localparam logic [1:0] OP_UDIV  = 2'b10;
   localparam logic [1:0] OP_SDIV  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   input  logic               is_div,
   input  logic               in_bit,
   output logic [2*WIDTH-1:0] acc_out,
   output logic               q_bit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_new;

   always_comb begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
      rem_sh  = {acc_in[2*WIDTH-1:WIDTH], in_bit};
      // The shifted remainder can exceed 2^WIDTH, so compare rather than rely on a borrow bit.
      q_bit   = is_div && (rem_sh >= {1'b0, operand});
      diff    = rem_sh[WIDTH-1:0] - operand;
      rem_new = q_bit ? diff : rem_sh[WIDTH-1:0];
      if (is_div) begin
         acc_out = {rem_new, acc_in[WIDTH-2:0], q_bit};
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide responder: WIDTH-cycle CALC loop, sign fixup, one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | one shift-add / shift-subtract iteration per cycle
// FIX     | sign correction, special cases, output registers written
// DONE    | done pulse; a new start is accepted here
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [1:0]       flags,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic [1:0]         flags_q, flags_d;
   logic               div_zero_q, div_zero_d;

   logic               is_div;
   logic               step_in_bit;
   logic [WIDTH-1:0]   step_operand;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_q_bit;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_quo;
   logic [WIDTH-1:0]   fix_rem;
   logic               req_sign_a;
   logic               req_sign_b;

   assign is_div       = op_q[1];
   // Multiplier bits are consumed LSB first, dividend bits MSB first.
   assign step_in_bit  = is_div ? mag_a_q[CNT_LAST - cnt_q] : mag_b_q[cnt_q];
   assign step_operand = is_div ? mag_b_q : mag_a_q;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_in  (acc_q),
      .operand (step_operand),
      .is_div  (is_div),
      .in_bit  (step_in_bit),
      .acc_out (step_acc),
      .q_bit   (step_q_bit)
   );

   assign req_sign_a = op[0] & a[WIDTH-1];
   assign req_sign_b = op[0] & b[WIDTH-1];

   always_comb begin
      fix_prod = ((op_q == OP_SMULL) && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
      fix_quo  = ((op_q == OP_SDIV) && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0]
                                                             : acc_q[WIDTH-1:0];
      fix_rem  = ((op_q == OP_SDIV) && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                                 : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      a_raw_d    = a_raw_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      acc_d      = acc_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      flags_d    = flags_q;
      div_zero_d = div_zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               op_d     = op;
               sign_a_d = req_sign_a;
               sign_b_d = req_sign_b;
               mag_a_d  = req_sign_a ? -a : a;
               mag_b_d  = req_sign_b ? -b : b;
               a_raw_d  = a;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_CALC;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (!is_div) begin
               res_lo_d   = fix_prod[WIDTH-1:0];
               res_hi_d   = fix_prod[2*WIDTH-1:WIDTH];
               flags_d    = {fix_prod[2*WIDTH-1], fix_prod == '0};
               div_zero_d = 1'b0;
            end else if (mag_b_q == '0) begin
               res_lo_d   = '0;
               res_hi_d   = a_raw_q;
               flags_d    = 2'b01;
               div_zero_d = 1'b1;
            end else begin
               // MIN/-1 needs no special path: |MIN|/1 negated wraps back to MIN, remainder 0.
               res_lo_d   = fix_quo;
               res_hi_d   = fix_rem;
               flags_d    = {fix_quo[WIDTH-1], fix_quo == '0};
               div_zero_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         a_raw_q    <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         acc_q      <= '0;
         res_lo_q   <= '0;
         res_hi_q   <= '0;
         flags_q    <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         a_raw_q    <= a_raw_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         acc_q      <= acc_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         flags_q    <= flags_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done      = (state_q == ST_DONE);
   assign result_lo = res_lo_q;
   assign result_hi = res_hi_q;
   assign flags     = flags_q;
   assign div_zero  = div_zero_q;

endmodule
